// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops plus an
// iterative shift-add multiply, with valid/ready on both sides.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_ill;
    logic [WIDTH-1:0] w_acc_next;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_ill;

    assign w_accept   = in_valid & in_ready;
    assign w_is_mul   = (alu_ctrl == 4'b1000);
    assign w_sum      = op_a + op_b;
    assign w_diff     = op_a - op_b;
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Single-cycle result and flags from the live request operands
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        unique case (alu_ctrl)
            4'b0000: w_res = op_a & op_b;
            4'b0001: w_res = op_a | op_b;
            4'b0010: begin
                w_res = w_sum;
                w_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0110: begin
                w_res = w_diff;
                w_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0111: w_res = {{(WIDTH-1){1'b0}},
                              ($signed(op_a) < $signed(op_b))};
            4'b1100: w_res = ~(op_a | op_b);
            4'b1000: w_res = '0;
            default: w_ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: multiply takes the iterative path, all else goes to DONE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_is_mul ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (r_cnt == LAST) w_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs depend on state only
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Datapath: capture on accept, iterate multiply, hold result in DONE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else if (w_accept) begin
                        r_result <= w_res;
                        r_zero   <= (w_res == '0);
                        r_ovf    <= w_ovf;
                        r_ill    <= w_ill;
                    end
                end
                S_MUL: begin
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_acc    <= w_acc_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_result <= w_acc_next;
                        r_zero   <= (w_acc_next == '0);
                        r_ovf    <= 1'b0;
                        r_ill    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign overflow = r_ovf;
    assign illegal  = r_ill;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: scoreboard of expected
// results checked against the unit's output handshake.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         illegal;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         o;
        logic         i;
    } exp_t;

    exp_t sbq[$];
    int   total;
    int   bad;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model, written with widened arithmetic
    function automatic exp_t model(input logic [3:0] c,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        logic [2*W-1:0] p;
        e = '0;
        case (c)
            4'd0:  e.r = a & b;
            4'd1:  e.r = a | b;
            4'd2: begin
                s = {a[W-1], a} + {b[W-1], b};
                e.r = s[W-1:0];
                e.o = s[W] ^ s[W-1];
            end
            4'd6: begin
                s = {a[W-1], a} - {b[W-1], b};
                e.r = s[W-1:0];
                e.o = s[W] ^ s[W-1];
            end
            4'd7:  e.r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd12: e.r = ~(a | b);
            4'd8: begin
                p = (2*W)'(a) * (2*W)'(b);
                e.r = p[W-1:0];
            end
            default: e.i = 1'b1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic send(input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int tacc);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready=%b want=1", in_ready);
        end
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        tacc     = cyc;
        sbq.push_back(model(c, a, b));
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        alu_ctrl = 4'($urandom);
    endtask

    task automatic collect(input int tacc, output exp_t got,
                           output int lat, output bit busy_ok,
                           output bit seen);
        busy_ok = 1'b1;
        seen    = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
        end
        got = {result, zero, overflow, illegal};
        lat = cyc - tacc;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctrl  = '0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        total++;
        if ({in_ready, out_valid, result, zero, overflow, illegal} !==
            {1'b1, 1'b0, 35'd0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b r=%h z=%b o=%b i=%b want rdy=1 vld=0 all 0",
                     in_ready, out_valid, result, zero, overflow, illegal);
        end
    endtask

    task automatic test_add_ovf();
        int t, lat;
        bit bz, sn;
        exp_t g, e;
        send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e) begin
            bad++;
            $display("FAIL add_result got=%h want=%h", g, e);
        end
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL add_latency got=%0d want=1", lat);
        end
        @(negedge clk);
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL add_handoff got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_sub_slt();
        int t, lat;
        bit bz, sn;
        exp_t g, e;
        send(4'b0110, 32'h5, 32'h5, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e) begin
            bad++;
            $display("FAIL sub_zero got=%h want=%h", g, e);
        end
        @(negedge clk);
        send(4'b0111, 32'hFFFF_FFFF, 32'h1, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e) begin
            bad++;
            $display("FAIL slt_signed got=%h want=%h", g, e);
        end
        @(negedge clk);
        send(4'b1100, 32'h0F0F_0000, 32'h0000_00FF, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e) begin
            bad++;
            $display("FAIL nor_result got=%h want=%h", g, e);
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        int t, lat;
        bit bz, sn;
        exp_t g, e;
        send(4'b1000, 32'h0001_0003, 32'h0000_0005, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e) begin
            bad++;
            $display("FAIL mul_small got=%h want=%h", g, e);
        end
        total++;
        if (lat !== W + 1) begin
            bad++;
            $display("FAIL mul_latency got=%0d want=%0d", lat, W + 1);
        end
        total++;
        if (!bz) begin
            bad++;
            $display("FAIL mul_busy in_ready rose got=1 want=0");
        end
        @(negedge clk);
        send(4'b1000, 32'hFFFF_FFFF, 32'h0000_0002, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e) begin
            bad++;
            $display("FAIL mul_wrap got=%h want=%h", g, e);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int t, lat;
        bit bz, sn;
        exp_t g, e;
        out_ready = 1'b0;
        send(4'b0001, 32'hF0F0_0000, 32'h0000_F0F0, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e) begin
            bad++;
            $display("FAIL or_result got=%h want=%h", g, e);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({result, zero, overflow, illegal} !== e ||
                {out_valid, in_ready} !== 2'b10) begin
                bad++;
                $display("FAIL bp_hold%0d got r=%h vld=%b rdy=%b want r=%h vld=1 rdy=0",
                         k, result, out_valid, in_ready, e.r);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_illegal();
        int t, lat;
        bit bz, sn;
        exp_t g, e;
        send(4'b0011, 32'h1234_5678, 32'h1, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e || lat !== 1) begin
            bad++;
            $display("FAIL illegal_code got=%h lat=%0d want=%h lat=1", g, lat, e);
        end
        @(negedge clk);
        send(4'b0000, 32'hFF, 32'h0F, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e) begin
            bad++;
            $display("FAIL and_after_illegal got=%h want=%h", g, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t, lat;
        bit bz, sn, leak;
        exp_t g, e;
        send(4'b1000, 32'h3, 32'h7, t);
        void'(sbq.pop_back());
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++;
        if ({in_ready, out_valid, result, zero, overflow, illegal} !==
            {1'b1, 1'b0, 35'd0}) begin
            bad++;
            $display("FAIL mid_reset got rdy=%b vld=%b r=%h z=%b o=%b i=%b want rdy=1 vld=0 all 0",
                     in_ready, out_valid, result, zero, overflow, illegal);
        end
        leak = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            if (out_valid) leak = 1'b1;
            @(negedge clk);
        end
        total++;
        if (leak) begin
            bad++;
            $display("FAIL mid_reset_leak got out_valid=1 want=0");
        end
        send(4'b0010, 32'h2, 32'h3, t);
        collect(t, g, lat, bz, sn);
        e = sbq.pop_front();
        total++;
        if (!sn || g !== e || lat !== 1) begin
            bad++;
            $display("FAIL add_after_reset got=%h lat=%0d want=%h lat=1", g, lat, e);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        @(negedge clk);
        test_reset();
        test_add_ovf();
        test_sub_slt();
        test_mul();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        total++;
        if (sbq.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder; performs the selected operation on two operands and returns a registered result with flags.
- Sits between the register-file read stage and writeback in the multi-cycle datapath variant.
- Valid/ready handshake on both sides; single-cycle ops, plus an iterative shift-add multiply.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
alu_ctrl  input  4  ALU control code
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB only)
illegal  output  1  alu_ctrl not a supported code

Behaviour:
- Reset: synchronous, sampled on clk rising edge while reset_n=0.
  - Reset state: state=IDLE, out_valid=0, result=0, zero=0, overflow=0, illegal=0, iteration counter=0, in_ready=1 after the reset edge.
  - Reset mid-operation aborts the operation; no result is ever presented for it.
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed; result 1 or 0, zero-extended), 1100 NOR, 1000 MUL (low WIDTH bits of unsigned product).
  - Any other code: result=0, illegal=1, zero=1, overflow=0.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = signed overflow of ADD/SUB; 0 for all other codes.
  - zero = (result==0) for every code.
- FSM states: IDLE, MUL, DONE.
  - in_ready = (state==IDLE), combinational from state only.
  - Accept = in_valid & in_ready. op_a, op_b and alu_ctrl are captured on the accept edge; later input changes are ignored.
  - IDLE + accept, non-MUL code: compute and register result and flags; go to DONE. out_valid=1 the cycle after accept (latency 1).
  - IDLE + accept, MUL: load multiplicand, multiplier and accumulator; counter=0; go to MUL.
  - MUL, per cycle: if multiplier LSB=1, add multiplicand to accumulator; shift multiplicand left 1; shift multiplier right 1; counter+1. After WIDTH iterations, register result and flags and go to DONE. out_valid rises exactly WIDTH+1 cycles after accept.
  - DONE: out_valid=1. result, zero, overflow and illegal are held stable while out_ready=0.
  - DONE on out_valid & out_ready: go to IDLE. out_valid=0 and in_ready=1 on the next cycle.
  - No overlap: a new request is never accepted in the same cycle a result is handed off (minimum 2 cycles per operation).
- in_valid while in_ready=0 has no effect; the requester must hold it.
- Outputs other than out_valid keep their last values in IDLE. Consumers must only sample them qualified by out_valid.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid exactly 1 cycle after accept; result=0x80000000, overflow=1, zero=0, illegal=0.
- SUB 0x00000005 - 0x00000005 -> result=0, zero=1, overflow=0. Then SLT 0xFFFFFFFF vs 0x00000001 -> result=0x00000001.
- MUL 0x00010003 * 0x00000005 -> result=0x0005000F. in_ready=0 for the 33 cycles until the result is presented; out_valid rises exactly 33 cycles after accept. MUL 0xFFFFFFFF * 0x00000002 -> result 0xFFFFFFFE.
- Backpressure: OR 0xF0F00000 | 0x0000F0F0 with out_ready=0 for 5 cycles -> result=0xF0F0F0F0 held, out_valid=1, in_ready=0 throughout. out_ready=1 -> handoff; in_ready=1 the next cycle.
- Illegal code 0011 with operands 0x12345678, 0x1 -> result=0, illegal=1, zero=1, latency 1. Next legal op (AND 0xFF & 0x0F=0x0F) -> illegal=0.
- reset_n=0 for 1 cycle on the 10th MUL iteration -> next cycle out_valid=0, in_ready=1, all flags 0. A following ADD 2+3 returns 5 with latency 1.
